writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Writeback stage that drives the register file's single write port (RegWrite, write_addr, write_data) from two producers: the ALU result path and the data-memory load-return path.
- ALU results never stall. Load returns are buffered in a small FIFO and drained on cycles with no ALU write.
- A per-register pending-load scoreboard gives the issue stage busy flags for load-use hazard stalls.

Parameters:
DW, 16, data width of register-file write data
AW, 3, register address width (8 registers)
DEPTH, 4, load-return FIFO entries (power of two, >=2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU result present this cycle; always accepted
alu_addr  input  AW  ALU destination register
alu_data  input  DW  ALU result
ld_valid  input  1  load-return data valid
ld_ready  output  1  FIFO can accept a load return (= not full)
ld_addr  input  AW  load destination register
ld_data  input  DW  loaded data
pend_set  input  1  issue stage has dispatched a load to pend_addr
pend_addr  input  AW  destination register of the dispatched load
qa  input  AW  operand A register queried by issue
qb  input  AW  operand B register queried by issue
qa_busy  output  1  load pending for qa (combinational from scoreboard)
qb_busy  output  1  load pending for qb
RegWrite  output  1  register-file write enable (registered)
write_addr  output  AW  register-file write address (registered)
write_data  output  DW  register-file write data (registered)
idle  output  1  FIFO empty, all counters zero, RegWrite low

Behaviour:
- Reset, asynchronous:
  - RegWrite=0, write_addr=0, write_data=0.
  - FIFO read/write pointers=0 (empty); all scoreboard counters=0.
  - Inputs sampled while reset is high are ignored.
- Load push: when ld_valid && ld_ready at a clock edge, {ld_addr, ld_data} is written to the FIFO tail.
- ld_ready = !full, registered-state only. No combinational path from this cycle's pop; a full FIFO shows ld_ready=0 even on a drain cycle.
- Write-port select, each cycle, fixed priority:
  1. alu_valid=1: next RegWrite=1, write_addr=alu_addr, write_data=alu_data. FIFO is not popped.
  2. Else, FIFO non-empty: pop the head; next RegWrite=1 with the head addr/data.
  3. Else: next RegWrite=0; write_addr/write_data hold their previous values.
- Latency:
  - ALU: exactly 1 cycle, input edge to RegWrite high.
  - Load return, empty FIFO, no ALU contention: 2 cycles (push edge, pop edge, RegWrite the cycle after the pop).
  - Loads drain in strict arrival order.
- Same-cycle push and pop: both happen; occupancy is unchanged. A load pushed into an empty FIFO is not popped in the same cycle.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs equal; empty = pointers equal.
- Scoreboard: one 3-bit counter per register.
  - pend_set increments the counter at pend_addr.
  - A FIFO pop decrements the counter at the popped addr.
  - Same register, same cycle, increment and decrement: counter unchanged.
  - Saturation: increment at 7 is dropped; decrement at 0 is dropped. The issue stage guarantees neither happens in legal operation.
  - qa_busy = (cnt[qa] != 0); qb_busy = (cnt[qb] != 0).
  - A pend_set in cycle N makes busy visible in cycle N+1.
  - A pop in cycle N clears busy in cycle N+1, the same cycle RegWrite writes the value. The issue stage reads the register file after that edge.
- ALU writes do not touch the scoreboard. An ALU write to a register with a pending load is legal (WAW); the later load overwrites it.
- idle is combinational from registered state.
- Reset mid-operation: FIFO contents and pending counts are discarded immediately; RegWrite drops in the reset cycle.

Test Plan:
- Reset check: assert reset mid-run with FIFO holding 2 entries -> RegWrite=0, write_addr=0, write_data=0, ld_ready=1, qa_busy=0, idle=1 while reset high.
- ALU only: alu_valid=1, addr=3, data=16'h1234 for 1 cycle -> next cycle RegWrite=1, write_addr=3, write_data=16'h1234; following cycle RegWrite=0.
- Contention: alu_valid and ld_valid in the same cycle (ALU r1=16'h00AA, load r2=16'h5555) -> cycle+1 writes r1=16'h00AA; cycle+2 writes r2=16'h5555.
- Backpressure: hold alu_valid=1 and push 4 loads -> ld_ready=0 after the 4th. Drop alu_valid -> 4 writes in push order on consecutive cycles; ld_ready=1 one cycle after the first pop.
- Scoreboard: pend_set r5 twice, then load returns to r5 -> qa=5 busy stays 1 after the first writeback; goes 0 the cycle the second writeback's RegWrite is high. pend_set r5 in the same cycle as a pop of r5 -> count unchanged.
- Wrap-around: push/pop 10 loads with random ALU gaps -> all 10 written in order, no loss or duplication; idle=1 at end.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: drives the register-file write port from the ALU result path
// and a buffered load-return path, and keeps a per-register pending-load count
// that the issue stage uses to detect load-use hazards.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   alu_valid/addr/data     ALU result, always accepted, highest priority
//   ld_valid/addr/data      load return, pushed into the FIFO when ld_ready
//   ld_ready                FIFO not full (registered state only)
//   pend_set/pend_addr      load dispatched to pend_addr (scoreboard increment)
//   qa/qb, qa_busy/qb_busy  operand queries and their pending-load flags
//   RegWrite/write_addr/write_data  registered register-file write port
//   idle                    FIFO empty, no pending loads, no write in flight
module writeback_unit #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          pend_set,
  input  logic [AW-1:0] pend_addr,
  input  logic [AW-1:0] qa,
  input  logic [AW-1:0] qb,
  output logic          qa_busy,
  output logic          qb_busy,
  output logic          RegWrite,
  output logic [AW-1:0] write_addr,
  output logic [DW-1:0] write_data,
  output logic          idle
);

  localparam int unsigned IW   = $clog2(DEPTH);
  localparam int unsigned PW   = IW + 1;
  localparam int unsigned NREG = 1 << AW;
  localparam int unsigned CW   = 3;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [CW-1:0] cnt     [NREG];
  logic [CW-1:0] cnt_nxt [NREG];
  logic          any_pend;

  // FIFO status from registered pointers only; the extra MSB separates full from empty
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign ld_ready  = !full;
  assign push      = ld_valid && !full;
  assign pop       = !alu_valid && !empty;
  assign head_addr = fifo_addr[rd_ptr[IW-1:0]];
  assign head_data = fifo_data[rd_ptr[IW-1:0]];

  // FIFO pointers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr[IW-1:0]] <= ld_addr;
      fifo_data[wr_ptr[IW-1:0]] <= ld_data;
    end
  end

  // Write port: ALU first, then FIFO head; address/data hold when idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      RegWrite   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else if (alu_valid) begin
      RegWrite   <= 1'b1;
      write_addr <= alu_addr;
      write_data <= alu_data;
    end else if (!empty) begin
      RegWrite   <= 1'b1;
      write_addr <= head_addr;
      write_data <= head_data;
    end else begin
      RegWrite   <= 1'b0;
    end
  end

  // Scoreboard next state: coincident inc/dec on one register cancel, ends saturate
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_nxt[i] = cnt[i];
      if ((pend_set && (pend_addr == AW'(i))) && !(pop && (head_addr == AW'(i)))) begin
        if (cnt[i] != '1) cnt_nxt[i] = cnt[i] + CW'(1);
      end else if ((pop && (head_addr == AW'(i))) && !(pend_set && (pend_addr == AW'(i)))) begin
        if (cnt[i] != '0) cnt_nxt[i] = cnt[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  always_comb begin
    any_pend = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (cnt[i] != '0) any_pend = 1'b1;
    end
  end

  assign qa_busy = (cnt[qa] != '0);
  assign qb_busy = (cnt[qb] != '0);
  assign idle    = empty && !any_pend && !RegWrite;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: a queue-based reference model predicts every
// register-file write and the scoreboard flags; a monitor compares each cycle.
module tb_writeback_unit;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_addr  = '0;
  logic [DW-1:0] alu_data  = '0;
  logic          ld_valid  = 1'b0;
  logic          ld_ready;
  logic [AW-1:0] ld_addr   = '0;
  logic [DW-1:0] ld_data   = '0;
  logic          pend_set  = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [AW-1:0] qa = '0;
  logic [AW-1:0] qb = '0;
  logic          qa_busy;
  logic          qb_busy;
  logic          RegWrite;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          idle;

  writeback_unit #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .pend_set(pend_set), .pend_addr(pend_addr),
    .qa(qa), .qb(qb), .qa_busy(qa_busy), .qb_busy(qb_busy),
    .RegWrite(RegWrite), .write_addr(write_addr), .write_data(write_data),
    .idle(idle)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  // Reference model state
  wr_t           ldq[$];
  wr_t           expq[$];
  int            pend[8];
  logic          exp_rw = 1'b0;
  logic [AW-1:0] hold_a = '0;
  logic [DW-1:0] hold_d = '0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_idle();
    bit r;
    r = (ldq.size() == 0) && !exp_rw;
    for (int i = 0; i < 8; i++) if (pend[i] != 0) r = 0;
    return r;
  endfunction

  // Model: one write per cycle, ALU wins, loads leave in arrival order
  always @(posedge clock or posedge reset) begin : model
    int  occ;
    bit  popped;
    wr_t h;
    if (reset) begin
      ldq.delete();
      expq.delete();
      for (int i = 0; i < 8; i++) pend[i] = 0;
      exp_rw = 1'b0;
      hold_a = '0;
      hold_d = '0;
    end else begin
      occ    = ldq.size();
      popped = 0;
      h      = '0;
      if (alu_valid) begin
        exp_rw = 1'b1;
        hold_a = alu_addr;
        hold_d = alu_data;
        expq.push_back(wr_t'({alu_addr, alu_data}));
      end else if (occ > 0) begin
        h      = ldq.pop_front();
        popped = 1;
        exp_rw = 1'b1;
        hold_a = h.a;
        hold_d = h.d;
        expq.push_back(h);
      end else begin
        exp_rw = 1'b0;
      end
      if (ld_valid && occ < int'(DEPTH)) ldq.push_back(wr_t'({ld_addr, ld_data}));
      if (pend_set && !(popped && h.a == pend_addr)) begin
        if (pend[pend_addr] < 7) pend[pend_addr]++;
      end
      if (popped && !(pend_set && pend_addr == h.a)) begin
        if (pend[h.a] > 0) pend[h.a]--;
      end
    end
  end

  // Monitor: compares DUT outputs to the model on the falling edge
  always @(negedge clock) begin : monitor
    wr_t e;
    chk("RegWrite", 32'(RegWrite), 32'(exp_rw));
    chk("ld_ready", 32'(ld_ready), 32'(ldq.size() < int'(DEPTH)));
    chk("qa_busy",  32'(qa_busy),  32'(pend[qa] != 0));
    chk("qb_busy",  32'(qb_busy),  32'(pend[qb] != 0));
    chk("idle",     32'(idle),     32'(model_idle()));
    if (RegWrite) begin
      if (expq.size() == 0) begin
        chk("unexpected_write", 32'(1), 32'(0));
      end else begin
        e = expq.pop_front();
        chk("write_addr", 32'(write_addr), 32'(e.a));
        chk("write_data", 32'(write_data), 32'(e.d));
      end
    end else begin
      chk("hold_addr", 32'(write_addr), 32'(hold_a));
      chk("hold_data", 32'(write_data), 32'(hold_d));
    end
  end

  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                      input logic ps, input logic [AW-1:0] pa);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid  = lv; ld_addr  = la; ld_data  = ldd;
    pend_set  = ps; pend_addr = pa;
    @(posedge clock);
    #2;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0, '0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : stim
    logic [AW-1:0] a;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;

    // ALU only
    step(1, 3'd3, 16'h1234, 0, '0, '0, 0, '0);
    nop(2);

    // ALU and load collide
    step(1, 3'd1, 16'h00AA, 1, 3'd2, 16'h5555, 0, '0);
    nop(3);

    // Backpressure: ALU blocks the drain while 4 loads fill the FIFO
    for (int i = 0; i < 4; i++) step(1, 3'(i), 16'(16'hA000 + i), 1, 3'(i + 4), 16'(16'hB000 + i), 0, '0);
    step(1, 3'd7, 16'hA004, 1, 3'd7, 16'hDEAD, 0, '0);
    chk("full_ld_ready", 32'(ld_ready), 32'(0));
    nop(6);

    // Scoreboard: two pending loads to r5
    qa = 3'd5; qb = 3'd2;
    step(0, '0, '0, 0, '0, '0, 1, 3'd5);
    step(0, '0, '0, 0, '0, '0, 1, 3'd5);
    nop(1);
    step(0, '0, '0, 1, 3'd5, 16'h0501, 0, '0);
    nop(1);
    step(0, '0, '0, 1, 3'd5, 16'h0502, 0, '0);
    nop(3);
    // pend_set coincides with the pop of r5
    step(0, '0, '0, 0, '0, '0, 1, 3'd5);
    step(0, '0, '0, 1, 3'd5, 16'h0503, 0, '0);
    step(0, '0, '0, 0, '0, '0, 1, 3'd5);
    nop(1);
    chk("sb_cancel_busy", 32'(qa_busy), 32'(1));
    step(0, '0, '0, 1, 3'd5, 16'h0504, 0, '0);
    nop(3);

    // Reset mid-run with two buffered loads
    step(1, 3'd6, 16'h6666, 1, 3'd1, 16'h1111, 1, 3'd1);
    step(1, 3'd6, 16'h6667, 1, 3'd2, 16'h2222, 1, 3'd2);
    qa = 3'd1;
    reset = 1'b1;
    #1;
    chk("rst_RegWrite", 32'(RegWrite), 32'(0));
    chk("rst_addr", 32'(write_addr), 32'(0));
    chk("rst_data", 32'(write_data), 32'(0));
    chk("rst_ld_ready", 32'(ld_ready), 32'(1));
    chk("rst_qa_busy", 32'(qa_busy), 32'(0));
    chk("rst_idle", 32'(idle), 32'(1));
    @(posedge clock); #2;
    @(posedge clock); #2;
    reset = 1'b0;
    nop(2);

    // Ten loads with random ALU gaps, each pended on push
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(0, 2)) step(1, 3'($urandom), 16'($urandom), 0, '0, '0, 0, '0);
      a  = 3'($urandom);
      qa = a;
      qb = 3'($urandom);
      step(0, '0, '0, 1, a, 16'($urandom), 1, a);
    end
    nop(6);
    chk("wrap_idle", 32'(idle), 32'(1));

    // Mixed random traffic
    for (int k = 0; k < 400; k++) begin
      qa = 3'($urandom);
      qb = 3'($urandom);
      step(1'($urandom_range(0, 2) == 0), 3'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
           1'($urandom_range(0, 3) == 0), 3'($urandom));
    end
    nop(8);
    chk("expq_drained", 32'(expq.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
